// File: rtl/core_data_responder.sv
// core_data_responder
//   Subordinate endpoint that terminates a cluster core data port on a local
//   word-addressed memory. Requests are granted combinationally. Each granted
//   request returns exactly one response, in grant order, RspLatency cycles
//   later. Out-of-range or misaligned accesses are answered with an error.
//
// Ports
//   clk_i    : clock, all state on the rising edge
//   rst_i    : synchronous, active-high reset
//   req_i    : request {req, add, we, data, be}
//   rsp_o    : response {gnt, r_data, r_valid}
//   r_err_o  : error qualifier, meaningful only while rsp_o.r_valid is high
//   stall_i  : forces gnt low (backpressure injection)
//   busy_o   : high while at least one granted request is unanswered
//
// Handshake: gnt is the ready for req. A request transfers on a cycle where
//   req & gnt are both high. Without gnt, the requester holds its fields and
//   the request has no effect. The response side has no ready: r_valid is a
//   one-cycle pulse that the requester must always accept.

package core_data_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;
endpackage

module core_data_responder
  import core_data_pkg::*;
#(
  parameter int          NumWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h1000_0000,
  parameter int          RspLatency     = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  core_data_req_t req_i,
  output core_data_rsp_t rsp_o,
  output logic           r_err_o,
  input  logic           stall_i,
  output logic           busy_o
);

  localparam int          IdxW      = $clog2(NumWords);
  localparam logic [31:0] SpanBytes = 32'(NumWords * 4);
  localparam logic [31:0] MissData  = 32'hBADA_CCE5;

  logic [31:0] mem [NumWords];

  // Outstanding count: granted requests whose response has not yet retired.
  logic [3:0]  cnt;

  // Response shift pipeline. The last stage drives the response outputs.
  logic        pipe_valid [RspLatency];
  logic [31:0] pipe_data  [RspLatency];
  logic        pipe_err   [RspLatency];

  logic [31:0]   off;
  logic          hit;
  logic [IdxW-1:0] idx;
  logic          gnt;
  logic          rsp_valid;
  logic [31:0]   new_data;
  logic          new_err;

  // Address decode. The subtraction is allowed to wrap: any address below
  // BaseAddr becomes a huge offset and falls out of range.
  assign off = req_i.add - BaseAddr;
  assign hit = (off < SpanBytes) && (req_i.add[1:0] == 2'b00);
  assign idx = off[2 +: IdxW];

  assign rsp_valid = pipe_valid[RspLatency-1];

  // A response retiring this cycle frees its slot for a grant in the same
  // cycle, so a full responder still sustains one grant per retirement.
  assign gnt = req_i.req & ~stall_i & ~rst_i &
               ((cnt < 4'(MaxOutstanding)) | rsp_valid);

  // Response payload captured at the grant edge. Reads see the memory as it
  // stands before this edge, which already includes all earlier writes.
  always_comb begin
    new_data = MissData;
    new_err  = 1'b1;
    if (hit) begin
      new_err  = 1'b0;
      new_data = req_i.we ? 32'h0 : mem[idx];
    end
  end

  // Memory is deliberately not reset. Committed writes survive a reset.
  always_ff @(posedge clk_i) begin
    if (gnt && hit && req_i.we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_i.be[b]) mem[idx][8*b +: 8] <= req_i.data[8*b +: 8];
      end
    end
  end

  // Data and error only load alongside a valid entry. Between responses, the
  // outputs therefore hold the last delivered values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 4'd0;
      for (int i = 0; i < RspLatency; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= 32'h0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      cnt <= cnt + 4'(gnt) - 4'(rsp_valid);
      pipe_valid[0] <= gnt;
      if (gnt) begin
        pipe_data[0] <= new_data;
        pipe_err[0]  <= new_err;
      end
      for (int i = 1; i < RspLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_err[i]  <= pipe_err[i-1];
        end
      end
    end
  end

  assign rsp_o.gnt     = gnt;
  assign rsp_o.r_data  = pipe_data[RspLatency-1];
  assign rsp_o.r_valid = rsp_valid;
  assign r_err_o       = pipe_err[RspLatency-1];
  assign busy_o        = (cnt != 4'd0);

endmodule

// File: tb/tb_core_data_responder.sv
// Bench for core_data_responder. Three instances cover the latency and
// outstanding-depth configurations: u0 (lat 1, max 2), u1 (lat 3, max 4), and
// u2 (lat 4, max 2). A reference model checks every instance on every cycle.
// It keeps a per-instance memory image and a queue of expected responses
// tagged with their due cycle. Directed sequences add explicit checks on top.
module tb_core_data_responder;
  import core_data_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          NW   = 16;
  localparam int          LAT  [3] = '{1, 3, 4};
  localparam int          MAXO [3] = '{2, 4, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           stall;
  core_data_req_t req_s  [3];
  core_data_rsp_t rsp_s  [3];
  logic           err_s  [3];
  logic           busy_s [3];

  int   cyc = 0;
  logic chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  core_data_responder #(.NumWords(NW), .BaseAddr(BASE), .RspLatency(1), .MaxOutstanding(2)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[0]), .rsp_o(rsp_s[0]),
    .r_err_o(err_s[0]), .stall_i(stall), .busy_o(busy_s[0]));
  core_data_responder #(.NumWords(NW), .BaseAddr(BASE), .RspLatency(3), .MaxOutstanding(4)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[1]), .rsp_o(rsp_s[1]),
    .r_err_o(err_s[1]), .stall_i(stall), .busy_o(busy_s[1]));
  core_data_responder #(.NumWords(NW), .BaseAddr(BASE), .RspLatency(4), .MaxOutstanding(2)) u2 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[2]), .rsp_o(rsp_s[2]),
    .r_err_o(err_s[2]), .stall_i(stall), .busy_o(busy_s[2]));

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
    logic        err;
    logic        known;
  } pend_t;

  pend_t       exp_q [$];
  logic [31:0] mmem   [3][NW];
  logic        mknown [3][NW];

  always @(negedge clk) begin : sb
    int          head, pend, w;
    logic        due, eg;
    pend_t       p;
    logic [31:0] off, mask;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        head = -1;
        pend = 0;
        foreach (exp_q[j]) if (exp_q[j].inst == k) begin
          if (head < 0) head = j;
          pend++;
        end
        due = (head >= 0) && (exp_q[head].due == cyc);
        check($sformatf("u%0d r_valid", k), 32'(rsp_s[k].r_valid), 32'(due));
        if (due && rsp_s[k].r_valid) begin
          check($sformatf("u%0d r_err", k), 32'(err_s[k]), 32'(exp_q[head].err));
          if (exp_q[head].known)
            check($sformatf("u%0d r_data", k), rsp_s[k].r_data, exp_q[head].data);
        end
        eg = !rst && req_s[k].req && !stall && (pend < MAXO[k] || due);
        check($sformatf("u%0d gnt", k), 32'(rsp_s[k].gnt), 32'(eg));
        check($sformatf("u%0d busy", k), 32'(busy_s[k]), 32'(pend > 0));
        if (rst) begin
          for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].inst == k) exp_q.delete(j);
        end else begin
          if (due) exp_q.delete(head);
          if (eg) begin
            p.inst = k;
            p.due  = cyc + LAT[k];
            off    = req_s[k].add - BASE;
            if (off < NW * 4 && req_s[k].add[1:0] == 2'b00) begin
              w     = int'(off / 4);
              p.err = 1'b0;
              if (req_s[k].we) begin
                mask = {{8{req_s[k].be[3]}}, {8{req_s[k].be[2]}},
                        {8{req_s[k].be[1]}}, {8{req_s[k].be[0]}}};
                mmem[k][w]   = (mmem[k][w] & ~mask) | (req_s[k].data & mask);
                mknown[k][w] = mknown[k][w] | (req_s[k].be == 4'hF);
                p.data  = 32'h0;
                p.known = 1'b1;
              end else begin
                p.data  = mmem[k][w];
                p.known = mknown[k][w];
              end
            end else begin
              p.data  = 32'hBADA_CCE5;
              p.err   = 1'b1;
              p.known = 1'b1;
            end
            exp_q.push_back(p);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int k, input logic [31:0] a, input logic we,
                       input logic [31:0] d, input logic [3:0] be, output int gc);
    req_s[k] = '{req: 1'b1, add: a, we: we, data: d, be: be};
    gc = -1;
    for (int t = 0; t < 50 && gc < 0; t++) begin
      @(negedge clk);
      if (rsp_s[k].gnt) gc = cyc;
      @(posedge clk); #1;
    end
    req_s[k].req = 1'b0;
    check("grant within bound", 32'(gc >= 0), 32'd1);
  endtask

  task automatic wait_rsp(input int k, output logic [31:0] d, output logic e, output int rc);
    rc = -1;
    d  = 32'h0;
    e  = 1'b0;
    for (int t = 0; t < 50 && rc < 0; t++) begin
      @(negedge clk);
      if (rsp_s[k].r_valid) begin
        rc = cyc;
        d  = rsp_s[k].r_data;
        e  = err_s[k];
      end
    end
    @(posedge clk); #1;
    check("response within bound", 32'(rc >= 0), 32'd1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int t = 0; t < 60 && !idle; t++) begin
      @(negedge clk);
      idle = !busy_s[0] && !busy_s[1] && !busy_s[2];
      @(posedge clk); #1;
    end
    check("idle within bound", 32'(idle), 32'd1);
  endtask

  function automatic core_data_req_t rand_req();
    core_data_req_t r;
    int sel;
    sel    = int'($urandom_range(0, 7));
    r.req  = 1'b1;
    r.add  = BASE + 32'(4 * $urandom_range(0, NW - 1));
    if (sel == 0) r.add = BASE + 32'(NW * 4) + 32'(4 * $urandom_range(0, 7));
    if (sel == 1) r.add = r.add | 32'($urandom_range(1, 3));
    if (sel == 2) r.add = BASE - 32'd4;
    r.we   = 1'($urandom_range(0, 1));
    r.data = $urandom;
    r.be   = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // ---------------- vector table (u0, latency 1) ----------------
  typedef struct {
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  // ---------------- main sequence ----------------
  initial begin : main
    int          gc, rc, nv, ng, outst;
    logic [31:0] d;
    logic        e, exp_g;
    logic        gl [3];

    vecs[0]  = '{BASE + 32'h10, 1'b1, 32'hBADA_CCE5, 4'hF,    32'h0,         1'b0};
    vecs[1]  = '{BASE + 32'h10, 1'b1, 32'h1122_3344, 4'hF,    32'h0,         1'b0};
    vecs[2]  = '{BASE + 32'h10, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
    vecs[3]  = '{BASE + 32'h10, 1'b0, 32'h0,         4'hF,    32'h11BB_33DD, 1'b0};
    vecs[4]  = '{BASE,          1'b1, 32'hCAFE_F00D, 4'hF,    32'h0,         1'b0};
    vecs[5]  = '{BASE + 32'h40, 1'b0, 32'h0,         4'hF,    32'hBADA_CCE5, 1'b1};
    vecs[6]  = '{BASE + 32'h02, 1'b1, 32'hFFFF_FFFF, 4'hF,    32'hBADA_CCE5, 1'b1};
    vecs[7]  = '{BASE,          1'b0, 32'h0,         4'hF,    32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{BASE + 32'h3C, 1'b1, 32'h1234_5678, 4'hF,    32'h0,         1'b0};
    vecs[9]  = '{BASE + 32'h3C, 1'b1, 32'hFFFF_FFFF, 4'h0,    32'h0,         1'b0};
    vecs[10] = '{BASE + 32'h3C, 1'b0, 32'h0,         4'hF,    32'h1234_5678, 1'b0};
    vecs[11] = '{BASE - 32'h4,  1'b0, 32'h0,         4'hF,    32'hBADA_CCE5, 1'b1};
    vecs[12] = '{BASE + 32'h11, 1'b0, 32'h0,         4'hF,    32'hBADA_CCE5, 1'b1};
    vecs[13] = '{BASE + 32'h3C, 1'b1, 32'hAB00_0000, 4'b1000, 32'h0,         1'b0};
    vecs[14] = '{BASE + 32'h3C, 1'b0, 32'h0,         4'hF,    32'hAB34_5678, 1'b0};

    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < NW; w++) mknown[k][w] = 1'b0;
      req_s[k] = '{req: 1'b1, add: BASE, we: 1'b0, data: 32'h0, be: 4'hF};
      gl[k] = 1'b0;
    end
    rst   = 1'b1;
    stall = 1'b0;

    // Reset held three cycles with req asserted
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("reset gnt", 32'(rsp_s[k].gnt), 32'd0);
        check("reset r_valid", 32'(rsp_s[k].r_valid), 32'd0);
        check("reset r_data", rsp_s[k].r_data, 32'h0);
        check("reset busy", 32'(busy_s[k]), 32'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("gnt after reset", 32'(rsp_s[k].gnt), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) req_s[k].req = 1'b0;
    wait_idle();

    // Table-driven single transactions on u0
    for (int i = 0; i < 15; i++) begin
      issue(0, vecs[i].add, vecs[i].we, vecs[i].data, vecs[i].be, gc);
      wait_rsp(0, d, e, rc);
      check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d latency", i), 32'(rc - gc), 32'd1);
    end

    // Write at N, read of the same word at N+1
    req_s[0] = '{req: 1'b1, add: BASE + 32'h8, we: 1'b1, data: 32'h5A5A_0F0F, be: 4'hF};
    @(negedge clk);
    check("b2b write gnt", 32'(rsp_s[0].gnt), 32'd1);
    @(posedge clk); #1;
    req_s[0] = '{req: 1'b1, add: BASE + 32'h8, we: 1'b0, data: 32'h0, be: 4'hF};
    @(negedge clk);
    check("b2b read gnt", 32'(rsp_s[0].gnt), 32'd1);
    check("b2b write rsp valid", 32'(rsp_s[0].r_valid), 32'd1);
    check("b2b write rsp data", rsp_s[0].r_data, 32'h0);
    @(posedge clk); #1;
    req_s[0].req = 1'b0;
    @(negedge clk);
    check("b2b read rsp valid", 32'(rsp_s[0].r_valid), 32'd1);
    check("b2b read rsp data", rsp_s[0].r_data, 32'h5A5A_0F0F);
    @(posedge clk); #1;

    // Streaming on u1 (latency 3, max 4)
    for (int i = 0; i < 8; i++) issue(1, BASE + 32'(4 * i), 1'b1, 32'(i) * 32'h0101_0101, 4'hF, gc);
    wait_idle();
    for (int t = 0; t < 12; t++) begin
      if (t < 8) req_s[1] = '{req: 1'b1, add: BASE + 32'(4 * t), we: 1'b0, data: 32'h0, be: 4'hF};
      else req_s[1].req = 1'b0;
      @(negedge clk);
      if (t < 8) check("stream gnt", 32'(rsp_s[1].gnt), 32'd1);
      check("stream r_valid", 32'(rsp_s[1].r_valid), 32'(t >= 3 && t <= 10));
      if (t >= 3 && t <= 10) check("stream data", rsp_s[1].r_data, 32'(t - 3) * 32'h0101_0101);
      check("stream busy", 32'(busy_s[1]), 32'(t >= 1 && t <= 10));
      @(posedge clk); #1;
    end

    // Throttling on u2 (latency 4, max 2): grants at 0,1,4,5,8,9
    wait_idle();
    ng = 0;
    outst = 0;
    req_s[2] = '{req: 1'b1, add: BASE, we: 1'b0, data: 32'h0, be: 4'hF};
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      exp_g = (t == 0 || t == 1 || t == 4 || t == 5 || t == 8 || t == 9);
      check($sformatf("throttle gnt t%0d", t), 32'(rsp_s[2].gnt), 32'(exp_g));
      if (exp_g && t >= 4) check("throttle slot freed", 32'(rsp_s[2].r_valid), 32'd1);
      outst = outst + int'(rsp_s[2].gnt) - int'(rsp_s[2].r_valid);
      check("throttle outstanding", 32'(outst <= 2), 32'd1);
      gl[2] = rsp_s[2].gnt;
      @(posedge clk); #1;
      if (gl[2]) begin
        ng++;
        if (ng == 6) req_s[2].req = 1'b0;
        else req_s[2].add = BASE + 32'(4 * ng);
      end
    end

    // Stall and reset mid-flight on u2
    wait_idle();
    req_s[2] = '{req: 1'b1, add: BASE, we: 1'b0, data: 32'h0, be: 4'hF};
    @(negedge clk);
    check("stall seq gnt0", 32'(rsp_s[2].gnt), 32'd1);
    @(posedge clk); #1;
    req_s[2].add = BASE + 32'h4;
    @(negedge clk);
    check("stall seq gnt1", 32'(rsp_s[2].gnt), 32'd1);
    @(posedge clk); #1;
    req_s[2].add = BASE + 32'h8;
    stall = 1'b1;
    nv = 0;
    for (int t = 2; t < 8; t++) begin
      @(negedge clk);
      check("stalled gnt", 32'(rsp_s[2].gnt), 32'd0);
      if (rsp_s[2].r_valid) nv++;
      @(posedge clk); #1;
    end
    check("responses drain under stall", 32'(nv), 32'd2);
    stall = 1'b0;
    @(negedge clk);
    check("unstall gnt", 32'(rsp_s[2].gnt), 32'd1);
    @(posedge clk); #1;
    req_s[2].add = BASE + 32'hC;
    @(negedge clk);
    check("second pair gnt", 32'(rsp_s[2].gnt), 32'd1);
    @(posedge clk); #1;
    req_s[2].req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("gnt low in reset", 32'(rsp_s[2].gnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("dropped r_valid", 32'(rsp_s[2].r_valid), 32'd0);
      check("cnt cleared", 32'(busy_s[2]), 32'd0);
      @(posedge clk); #1;
    end

    // Committed writes survive reset
    issue(0, BASE, 1'b0, 32'h0, 4'hF, gc);
    wait_rsp(0, d, e, rc);
    check("memory persists", d, 32'hCAFE_F00D);

    // Randomized traffic on all instances; requester holds fields until granted
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 3; k++) begin
        if (!req_s[k].req || gl[k]) begin
          if ($urandom_range(0, 3) == 0) req_s[k].req = 1'b0;
          else req_s[k] = rand_req();
        end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) gl[k] = rsp_s[k].gnt;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) req_s[k].req = 1'b0;
    stall = 1'b0;
    wait_idle();
    check("expected queue drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_chk);
    $fatal(1);
  end

endmodule
